// File: rtl/muldiv_seq.sv
// muldiv_seq: sequential RV M-extension unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
// Shift-add multiplier and restoring divider over unsigned magnitudes, with a
// one-cycle sign fix-up. Divide-by-zero and signed overflow take a 1-cycle fast path.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   in_valid/in_ready   request handshake; in_ready = IDLE && !rst
//   funct3, a, b        operation select and rs1/rs2 operands
//   kill                abort any in-flight operation, returns to IDLE
//   out_valid/out_ready result handshake; result and flags held until taken
//   result              registered XLEN-bit result
//   zero_division       divide op with b == 0
//   overflow_signed_div DIV/REM with a = -2^(XLEN-1), b = -1
//
// Build option: define MULDIV_FAST_MUL_EN for a single-cycle combinational
// multiplier (MUL* latency 1); divide behaviour is unchanged.
module muldiv_seq #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero_division,
  output logic            overflow_signed_div
);

  localparam int unsigned W2 = 2 * XLEN;
  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [W2-1:0]   r_acc, w_acc_nxt;       // {hi, lo}: product, or {remainder, quotient}
  logic [XLEN-1:0] r_opnd, w_opnd_nxt;     // multiplicand or divisor magnitude
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [2:0]      r_op, w_op_nxt;
  logic            r_neg_q, w_neg_q_nxt;   // product/quotient negated
  logic            r_neg_r, w_neg_r_nxt;   // remainder negated (sign of a)
  logic [XLEN-1:0] r_result, w_result_nxt;
  logic            r_zdiv, w_zdiv_nxt;
  logic            r_ovf, w_ovf_nxt;
  logic            r_out_valid, w_out_valid_nxt;

  logic            w_accept, w_is_div, w_a_signed, w_b_signed, w_a_neg, w_b_neg, w_ovf_case;
  logic [XLEN-1:0] w_a_mag, w_b_mag;
  logic [XLEN:0]   w_rem_sh, w_diff;
  logic [W2-1:0]   w_div_step, w_prod;
  logic [XLEN-1:0] w_quo, w_rem, w_fix_res;

  assign in_ready            = (r_state == S_IDLE) && !rst;
  assign out_valid           = r_out_valid;
  assign result              = r_result;
  assign zero_division       = r_zdiv;
  assign overflow_signed_div = r_ovf;

  // Operand sign interpretation and magnitudes at accept
  assign w_accept   = in_valid && in_ready && !kill;
  assign w_is_div   = funct3[2];
  assign w_a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                      (funct3 == 3'b100) || (funct3 == 3'b110);
  assign w_b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
  assign w_a_neg    = w_a_signed && a[XLEN-1];
  assign w_b_neg    = w_b_signed && b[XLEN-1];
  assign w_a_mag    = w_a_neg ? (~a + XLEN'(1)) : a;
  assign w_b_mag    = w_b_neg ? (~b + XLEN'(1)) : b;
  assign w_ovf_case = ((funct3 == 3'b100) || (funct3 == 3'b110)) &&
                      (a == MIN_NEG) && (b == {XLEN{1'b1}});

  // Restoring divide step: shift {rem,quo} left, keep the trial difference if non-negative
  assign w_rem_sh   = r_acc[W2-1:XLEN-1];
  assign w_diff     = w_rem_sh - {1'b0, r_opnd};
  assign w_div_step = w_diff[XLEN] ? {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                   : {w_diff[XLEN-1:0],   r_acc[XLEN-2:0], 1'b1};

  // Sign fix-up and result select
  assign w_prod    = r_neg_q ? (~r_acc + W2'(1)) : r_acc;
  assign w_quo     = r_neg_q ? (~r_acc[XLEN-1:0] + XLEN'(1)) : r_acc[XLEN-1:0];
  assign w_rem     = r_neg_r ? (~r_acc[W2-1:XLEN] + XLEN'(1)) : r_acc[W2-1:XLEN];
  assign w_fix_res = r_op[2] ? (r_op[1] ? w_rem : w_quo)
                             : ((r_op == 3'b000) ? w_prod[XLEN-1:0] : w_prod[W2-1:XLEN]);

`ifdef MULDIV_FAST_MUL_EN
  logic [W2-1:0] w_fast_mag, w_fast_prod;
  assign w_fast_mag  = W2'(w_a_mag) * W2'(w_b_mag);
  assign w_fast_prod = (w_a_neg ^ w_b_neg) ? (~w_fast_mag + W2'(1)) : w_fast_mag;
`else
  // Shift-add multiply step: conditionally add multiplicand to hi, shift right with carry
  logic [XLEN:0] w_sum;
  logic [W2-1:0] w_mul_step;
  assign w_sum      = {1'b0, r_acc[W2-1:XLEN]} + {1'b0, r_opnd};
  assign w_mul_step = r_acc[0] ? {w_sum, r_acc[XLEN-1:1]} : {1'b0, r_acc[W2-1:1]};
`endif

  // Next-state and datapath control
  always_comb begin
    w_state_nxt  = r_state;
    w_acc_nxt    = r_acc;
    w_opnd_nxt   = r_opnd;
    w_cnt_nxt    = r_cnt;
    w_op_nxt     = r_op;
    w_neg_q_nxt  = r_neg_q;
    w_neg_r_nxt  = r_neg_r;
    w_result_nxt = r_result;
    w_zdiv_nxt   = r_zdiv;
    w_ovf_nxt    = r_ovf;

    if (kill) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            w_op_nxt    = funct3;
            w_zdiv_nxt  = 1'b0;
            w_ovf_nxt   = 1'b0;
            w_neg_q_nxt = w_a_neg ^ w_b_neg;
            w_neg_r_nxt = w_a_neg;
            w_cnt_nxt   = '0;
            if (w_is_div) begin
              if (b == '0) begin
                w_result_nxt = funct3[1] ? a : {XLEN{1'b1}};
                w_zdiv_nxt   = 1'b1;
                w_state_nxt  = S_DONE;
              end else if (w_ovf_case) begin
                w_result_nxt = funct3[1] ? '0 : a;
                w_ovf_nxt    = 1'b1;
                w_state_nxt  = S_DONE;
              end else begin
                w_acc_nxt   = {XLEN'(0), w_a_mag};
                w_opnd_nxt  = w_b_mag;
                w_state_nxt = S_DIV;
              end
            end else begin
`ifdef MULDIV_FAST_MUL_EN
              w_result_nxt = (funct3 == 3'b000) ? w_fast_prod[XLEN-1:0] : w_fast_prod[W2-1:XLEN];
              w_state_nxt  = S_DONE;
`else
              w_acc_nxt   = {XLEN'(0), w_b_mag};
              w_opnd_nxt  = w_a_mag;
              w_state_nxt = S_MUL;
`endif
            end
          end
        end
`ifdef MULDIV_FAST_MUL_EN
`else
        S_MUL: begin
          w_acc_nxt = w_mul_step;
          w_cnt_nxt = r_cnt + CW'(1);
          if (r_cnt == CW'(XLEN - 1)) w_state_nxt = S_FIX;
        end
`endif
        S_DIV: begin
          w_acc_nxt = w_div_step;
          w_cnt_nxt = r_cnt + CW'(1);
          if (r_cnt == CW'(XLEN - 1)) w_state_nxt = S_FIX;
        end
        S_FIX: begin
          w_result_nxt = w_fix_res;
          w_state_nxt  = S_DONE;
        end
        S_DONE: begin
          if (out_ready) w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end

    w_out_valid_nxt = (w_state_nxt == S_DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_opnd      <= '0;
      r_cnt       <= '0;
      r_op        <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_result    <= '0;
      r_zdiv      <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_opnd      <= w_opnd_nxt;
      r_cnt       <= w_cnt_nxt;
      r_op        <= w_op_nxt;
      r_neg_q     <= w_neg_q_nxt;
      r_neg_r     <= w_neg_r_nxt;
      r_result    <= w_result_nxt;
      r_zdiv      <= w_zdiv_nxt;
      r_ovf       <= w_ovf_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq (XLEN = 32): results, flags, latency,
// backpressure, kill and mid-operation reset.
module tb_muldiv_seq;

  localparam int unsigned XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = XLEN + 2;
`endif
  localparam int DIV_LAT = XLEN + 2;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      funct3;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            kill;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero_division;
  logic            overflow_signed_div;

  int n_cmp;
  int n_err;

  muldiv_seq #(.XLEN(XLEN)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .funct3              (funct3),
    .a                   (a),
    .b                   (b),
    .kill                (kill),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .result              (result),
    .zero_division       (zero_division),
    .overflow_signed_div (overflow_signed_div)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one op, wait for out_valid, check result/flags/latency,
  // optionally hold out_ready low for 'hold' cycles, then retire it.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] ai,
                        input logic [31:0] bi, input logic [31:0] er, input logic ez,
                        input logic eo, input int elat, input int hold);
    int k;
    logic [31:0] held;
    @(negedge clk);
    check_eq({tag, "_rdy"}, 64'(in_ready), 64'(1));
    in_valid = 1'b1; funct3 = f; a = ai; b = bi; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check_eq({tag, "_lat"}, 64'(k + 1), 64'(elat));
    check_eq({tag, "_res"}, 64'(result), 64'(er));
    check_eq({tag, "_zd"}, 64'(zero_division), 64'(ez));
    check_eq({tag, "_ov"}, 64'(overflow_signed_div), 64'(eo));
    held = result;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_eq({tag, "_bp_res"}, 64'(result), 64'(held));
      check_eq({tag, "_bp_vld"}, 64'(out_valid), 64'(1));
      check_eq({tag, "_bp_rdy"}, 64'(in_ready), 64'(0));
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq({tag, "_ret_vld"}, 64'(out_valid), 64'(0));
    check_eq({tag, "_ret_rdy"}, 64'(in_ready), 64'(1));
  endtask

  initial begin
    int seen;
    n_cmp = 0; n_err = 0;
    clk = 1'b0; rst = 1'b1; in_valid = 1'b0; funct3 = '0; a = '0; b = '0;
    kill = 1'b0; out_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_rdy", 64'(in_ready), 64'(0));
    check_eq("rst_vld", 64'(out_valid), 64'(0));
    check_eq("rst_res", 64'(result), 64'(0));
    check_eq("rst_zd", 64'(zero_division), 64'(0));
    check_eq("rst_ov", 64'(overflow_signed_div), 64'(0));
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check_eq("post_rst_rdy", 64'(in_ready), 64'(1));

    // Multiply family
    run_op("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 1'b0, MUL_LAT, 0);
    run_op("mulh",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 1'b0, MUL_LAT, 0);
    run_op("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0, MUL_LAT, 0);
    run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 1'b0, 1'b0, MUL_LAT, 0);

    // Divide by zero and signed overflow fast paths
    run_op("divu_z", 3'b101, 32'd100,      32'd0,        32'hFFFFFFFF, 1'b1, 1'b0, 1, 0);
    run_op("remu_z", 3'b111, 32'd100,      32'd0,        32'd100,      1'b1, 1'b0, 1, 0);
    run_op("div_z",  3'b100, 32'hFFFFFFF0, 32'd0,        32'hFFFFFFFF, 1'b1, 1'b0, 1, 0);
    run_op("div_ov", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b1, 1, 0);
    run_op("rem_ov", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b0, 1'b1, 1, 0);

    // Iterative divide with signs
    run_op("div",    3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, 1'b0, DIV_LAT, 0);
    run_op("rem",    3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0, 1'b0, DIV_LAT, 0);
    run_op("div_nb", 3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 1'b0, DIV_LAT, 0);
    run_op("rem_nb", 3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        1'b0, 1'b0, DIV_LAT, 0);
    run_op("remu",   3'b111, 32'hFFFFFFF9, 32'd2,        32'd1,        1'b0, 1'b0, DIV_LAT, 0);

    // Backpressure: result held 10 cycles with out_ready low
    run_op("divu_bp", 3'b101, 32'hFFFFFFF9, 32'd2,       32'h7FFFFFFC, 1'b0, 1'b0, DIV_LAT, 10);

    // kill with in_valid while idle: nothing accepted
    @(negedge clk);
    in_valid = 1'b1; kill = 1'b1; funct3 = 3'b101; a = 32'd5; b = 32'd0;
    @(posedge clk); #1;
    in_valid = 1'b0; kill = 1'b0;
    check_eq("kill_idle_vld", 64'(out_valid), 64'(0));
    check_eq("kill_idle_rdy", 64'(in_ready), 64'(1));

    // kill at iteration 5 of a DIV, with in_valid asserted
    @(negedge clk);
    in_valid = 1'b1; funct3 = 3'b100; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    kill = 1'b1; in_valid = 1'b1; funct3 = 3'b101; b = 32'd0;
    @(posedge clk); #1;
    kill = 1'b0; in_valid = 1'b0;
    check_eq("kill_div_vld", 64'(out_valid), 64'(0));
    check_eq("kill_div_rdy", 64'(in_ready), 64'(1));
    check_eq("kill_div_res", 64'(result), 64'(32'h7FFFFFFC));
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check_eq("kill_no_vld", 64'(seen), 64'(0));

    // Reset pulse mid-MUL clears all outputs
    @(negedge clk);
    in_valid = 1'b1; funct3 = 3'b000; a = 32'd3; b = 32'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check_eq("rstmid_vld", 64'(out_valid), 64'(0));
    check_eq("rstmid_res", 64'(result), 64'(0));
    check_eq("rstmid_zd", 64'(zero_division), 64'(0));
    check_eq("rstmid_ov", 64'(overflow_signed_div), 64'(0));
    check_eq("rstmid_rdy", 64'(in_ready), 64'(0));
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check_eq("rstmid_rdy_after", 64'(in_ready), 64'(1));

    run_op("mul_after", 3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 1'b0, MUL_LAT, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
